// File: rtl/sine_rom_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : sine_rom_scheduler
//  Function : Shares one 1-cycle-latency sine ROM between two phase-
//             accumulating tone channels, one lookup per channel per tick.
//  Revision : 1.0  initial release
// ============================================================================
module sine_rom_scheduler #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [1:0]         en,
    input  logic [A_WIDTH-1:0] step0,
    input  logic [A_WIDTH-1:0] step1,
    output logic [A_WIDTH-1:0] rom_addr,
    input  logic [D_WIDTH-1:0] rom_data,
    output logic [D_WIDTH-1:0] dout0,
    output logic [D_WIDTH-1:0] dout1,
    output logic [1:0]         valid,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOOK0 = 3'd1,
        CAP0  = 3'd2,
        LOOK1 = 3'd3,
        CAP1  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] phase0_q, phase0_d;
    logic [A_WIDTH-1:0] phase1_q, phase1_d;
    logic               en_lat1_q, en_lat1_d;
    logic [D_WIDTH-1:0] dout0_q, dout0_d;
    logic [D_WIDTH-1:0] dout1_q, dout1_d;
    logic [1:0]         valid_q, valid_d;
    logic               overrun_q, overrun_d;

    // Only channel 1's latched enable is needed later: channel 0's choice is
    // fully resolved by the IDLE branch into LOOK0 versus LOOK1.
    always_comb begin
        state_d   = state_q;
        phase0_d  = phase0_q;
        phase1_d  = phase1_q;
        en_lat1_d = en_lat1_q;
        dout0_d   = dout0_q;
        dout1_d   = dout1_q;
        valid_d   = 2'b00;
        overrun_d = overrun_q;
        rom_addr  = phase0_q;

        case (state_q)
            IDLE: begin
                if (tick && (en != 2'b00)) begin
                    en_lat1_d = en[1];
                    if (en[0]) phase0_d = phase0_q + step0;
                    if (en[1]) phase1_d = phase1_q + step1;
                    state_d = en[0] ? LOOK0 : LOOK1;
                end
            end
            LOOK0: begin
                rom_addr = phase0_q;
                state_d  = CAP0;
            end
            CAP0: begin
                dout0_d    = rom_data;
                valid_d[0] = 1'b1;
                if (en_lat1_q) begin
                    // Issue channel 1's lookup while capturing channel 0.
                    rom_addr = phase1_q;
                    state_d  = CAP1;
                end else begin
                    state_d = IDLE;
                end
            end
            LOOK1: begin
                rom_addr = phase1_q;
                state_d  = CAP1;
            end
            CAP1: begin
                dout1_d    = rom_data;
                valid_d[1] = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (tick && (state_q != IDLE)) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            phase0_q  <= '0;
            phase1_q  <= '0;
            en_lat1_q <= 1'b0;
            dout0_q   <= '0;
            dout1_q   <= '0;
            valid_q   <= 2'b00;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase0_q  <= phase0_d;
            phase1_q  <= phase1_d;
            en_lat1_q <= en_lat1_d;
            dout0_q   <= dout0_d;
            dout1_q   <= dout1_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign dout0   = dout0_q;
    assign dout1   = dout1_q;
    assign valid   = valid_q;
    assign busy    = (state_q != IDLE);
    assign overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_sine_rom_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_sine_rom_scheduler
//  Function : Self-checking bench: vector table plus scoreboard of samples.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sine_rom_scheduler;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [1:0] en;
    logic [7:0] step0, step1;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] dout0, dout1;
    logic [1:0] valid;
    logic       busy, overrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } sb_t;

    typedef struct {
        bit         rst_first;
        logic [1:0] en;
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    sb_t  q0[$];
    sb_t  q1[$];
    vec_t vecs[12];

    sine_rom_scheduler #(.A_WIDTH(8), .D_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .en       (en),
        .step0    (step0),
        .step1    (step1),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .dout0    (dout0),
        .dout1    (dout1),
        .valid    (valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: data = addr ^ A5, one cycle of latency.
    initial rom_data = 8'h00;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rom_data <= rom_addr ^ 8'hA5;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every valid pulse must match the oldest pending sample.
    always @(negedge clk) begin : mon
        sb_t s;
        if (valid[0]) begin
            if (q0.size() == 0) begin
                checks++; failures++;
                $display("FAIL valid0_unexpected: dout0=%0h at cycle %0d, none required", dout0, cyc);
            end else begin
                s = q0.pop_front();
                check("dout0_sample", {24'd0, dout0}, {24'd0, s.data});
                check("valid0_cycle", cyc, s.cyc);
            end
        end
        if (valid[1]) begin
            if (q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL valid1_unexpected: dout1=%0h at cycle %0d, none required", dout1, cyc);
            end else begin
                s = q1.pop_front();
                check("dout1_sample", {24'd0, dout1}, {24'd0, s.data});
                check("valid1_cycle", cyc, s.cyc);
            end
        end
    end

    // All main-flow tasks start and end one time unit after a rising edge.
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_at(input logic [1:0] e, input logic [7:0] s0, input logic [7:0] s1,
                           output int c);
        en    = e;
        step0 = s0;
        step1 = s1;
        tick  = 1'b1;
        c     = cyc;
        wait_cycles(1);
        tick  = 1'b0;
    endtask

    task automatic expect_tick(input logic [1:0] e, input logic [7:0] e0, input logic [7:0] e1,
                               input int c);
        sb_t s;
        if (e[0]) begin
            s.data = e0; s.cyc = c + 3;
            q0.push_back(s);
        end
        if (e[1]) begin
            s.data = e1; s.cyc = e[0] ? c + 4 : c + 3;
            q1.push_back(s);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_dout0",    {24'd0, dout0},    32'd0);
        check("rst_dout1",    {24'd0, dout1},    32'd0);
        check("rst_valid",    {30'd0, valid},    32'd0);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_overrun",  {31'd0, overrun},  32'd0);
        check("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
        wait_cycles(2);
        rst = 1'b1;
        wait_cycles(1);
    endtask

    initial begin
        int         c;
        int         cd;
        logic [7:0] last0, last1;

        rst = 1'b1; tick = 1'b0; en = 2'b00; step0 = 8'h00; step1 = 8'h00;
        last0 = 8'h00; last1 = 8'h00;

        vecs[0]  = '{1'b1, 2'b01, 8'h10, 8'h00, 8'hB5, 8'h00};
        vecs[1]  = '{1'b0, 2'b01, 8'h10, 8'h00, 8'h85, 8'h00};
        vecs[2]  = '{1'b0, 2'b01, 8'h10, 8'h00, 8'h95, 8'h00};
        vecs[3]  = '{1'b1, 2'b11, 8'h01, 8'h40, 8'hA4, 8'hE5};
        vecs[4]  = '{1'b1, 2'b10, 8'h00, 8'hC0, 8'h00, 8'h65};
        vecs[5]  = '{1'b0, 2'b10, 8'h00, 8'hC0, 8'h00, 8'h25};
        vecs[6]  = '{1'b0, 2'b10, 8'h00, 8'hC0, 8'h00, 8'hE5};
        vecs[7]  = '{1'b0, 2'b11, 8'hF0, 8'h20, 8'h55, 8'hC5};
        vecs[8]  = '{1'b0, 2'b11, 8'h20, 8'hFF, 8'hB5, 8'hFA};
        vecs[9]  = '{1'b0, 2'b01, 8'h01, 8'h12, 8'hB4, 8'h00};
        vecs[10] = '{1'b0, 2'b10, 8'h33, 8'h01, 8'h00, 8'hC5};
        vecs[11] = '{1'b0, 2'b11, 8'h00, 8'h00, 8'hB4, 8'hC5};

        #2;
        do_reset();

        foreach (vecs[i]) begin
            if (vecs[i].rst_first) begin
                do_reset();
                last0 = 8'h00; last1 = 8'h00;
            end
            tick_at(vecs[i].en, vecs[i].s0, vecs[i].s1, c);
            expect_tick(vecs[i].en, vecs[i].e0, vecs[i].e1, c);
            if (vecs[i].en[0]) last0 = vecs[i].e0;
            if (vecs[i].en[1]) last1 = vecs[i].e1;
            wait_cycles(6);
            @(negedge clk);
            check("hold_dout0", {24'd0, dout0}, {24'd0, last0});
            check("hold_dout1", {24'd0, dout1}, {24'd0, last1});
            check("idle_busy",  {31'd0, busy},  32'd0);
            wait_cycles(1);
        end

        // Both channels: address and busy timeline.
        do_reset();
        tick_at(2'b11, 8'h01, 8'h40, c);
        expect_tick(2'b11, 8'hA4, 8'hE5, c);
        @(negedge clk);
        check("t1_rom_addr", {24'd0, rom_addr}, 32'h01);
        check("t1_busy", {31'd0, busy}, 32'd1);
        wait_cycles(1); @(negedge clk);
        check("t2_rom_addr", {24'd0, rom_addr}, 32'h40);
        check("t2_busy", {31'd0, busy}, 32'd1);
        wait_cycles(1); @(negedge clk);
        check("t3_busy", {31'd0, busy}, 32'd1);
        wait_cycles(1); @(negedge clk);
        check("t4_busy", {31'd0, busy}, 32'd0);
        wait_cycles(4);

        // Channel 1 only: phase1 40 -> 50.
        tick_at(2'b10, 8'h00, 8'h10, c);
        expect_tick(2'b10, 8'h00, 8'hF5, c);
        @(negedge clk);
        check("s1_rom_addr", {24'd0, rom_addr}, 32'h50);
        check("s1_busy", {31'd0, busy}, 32'd1);
        wait_cycles(1); @(negedge clk);
        check("s2_busy", {31'd0, busy}, 32'd1);
        wait_cycles(1); @(negedge clk);
        check("s3_busy", {31'd0, busy}, 32'd0);
        wait_cycles(4);

        // Dropped ticks: in a CAP0 returning to IDLE, in CAP0->CAP1, in CAP1.
        do_reset();
        tick_at(2'b01, 8'h10, 8'h00, c);
        expect_tick(2'b01, 8'hB5, 8'h00, c);
        @(negedge clk);
        check("ovr_before", {31'd0, overrun}, 32'd0);
        wait_cycles(1);
        tick_at(2'b01, 8'h10, 8'h00, cd);
        @(negedge clk);
        check("ovr_cap0_idle", {31'd0, overrun}, 32'd1);
        wait_cycles(6);
        tick_at(2'b01, 8'h10, 8'h00, c);
        expect_tick(2'b01, 8'h85, 8'h00, c);
        wait_cycles(6);

        do_reset();
        tick_at(2'b11, 8'h10, 8'h20, c);
        expect_tick(2'b11, 8'hB5, 8'h85, c);
        wait_cycles(1);
        tick_at(2'b11, 8'h10, 8'h20, cd);
        @(negedge clk);
        check("ovr_cap0", {31'd0, overrun}, 32'd1);
        wait_cycles(6);
        tick_at(2'b11, 8'h10, 8'h20, c);
        expect_tick(2'b11, 8'h85, 8'hE5, c);
        wait_cycles(6); @(negedge clk);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);
        wait_cycles(1);

        do_reset();
        tick_at(2'b10, 8'h00, 8'h10, c);
        expect_tick(2'b10, 8'h00, 8'hB5, c);
        wait_cycles(1);
        tick_at(2'b10, 8'h00, 8'h10, cd);
        @(negedge clk);
        check("ovr_cap1", {31'd0, overrun}, 32'd1);
        wait_cycles(6);
        tick_at(2'b10, 8'h00, 8'h10, c);
        expect_tick(2'b10, 8'h00, 8'h85, c);
        wait_cycles(6);

        // en/step changes while busy are ignored; an en=0 tick does nothing.
        do_reset();
        tick_at(2'b11, 8'h10, 8'h20, c);
        expect_tick(2'b11, 8'hB5, 8'h85, c);
        en = 2'b00; step0 = 8'hFF; step1 = 8'hFF;
        wait_cycles(6);
        tick_at(2'b00, 8'hFF, 8'hFF, cd);
        @(negedge clk);
        check("en0_busy", {31'd0, busy}, 32'd0);
        wait_cycles(5);
        tick_at(2'b01, 8'h00, 8'h00, c);
        expect_tick(2'b01, 8'hB5, 8'h00, c);
        wait_cycles(6);

        // Reset during CAP0 aborts the sequence.
        tick_at(2'b11, 8'h10, 8'h10, c);
        wait_cycles(1);
        do_reset();
        tick_at(2'b01, 8'h10, 8'h00, c);
        expect_tick(2'b01, 8'hB5, 8'h00, c);
        @(negedge clk);
        check("post_rst_addr", {24'd0, rom_addr}, 32'h10);
        wait_cycles(6);

        for (int i = 0; i < 20 && (q0.size() + q1.size()) != 0; i++) wait_cycles(1);
        check("scoreboard_drained", q0.size() + q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
